// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b LSB-first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LAST = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             ready_q, busy_q, done_q;
  logic             d_bit, bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // One full-subtractor step on the current LSBs
  assign d_bit = a_q[0] ^ b_q[0] ^ bin_q;
  assign bout  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          cnt_d    = '0;
          bin_d    = 1'b0;
          borrow_d = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_d    = 1'b0;
`endif
          state_d  = S_SHIFT;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bin_d  = bout;
        if (cnt_q == CW'(LAST)) begin
          state_d  = S_DONE;
          borrow_d = bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          // On the last step the operand LSBs are the original MSBs
          ovf_d    = (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      ready_q  <= (state_d != S_SHIFT);
      busy_q   <= (state_d == S_SHIFT);
      done_q   <= (state_d == S_DONE);
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor; the inverse arithmetic companion to the team's combinational full adder. It loads two WIDTH-bit operands on a start handshake and computes `a - b` LSB-first, one full-subtractor step per clock, using a registered borrow. It returns the difference and the final borrow with a one-cycle done pulse. It sits in area-constrained datapaths where a WIDTH-bit ripple subtractor is too large.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only when `ready` = 1
- `a`  in  WIDTH  minuend; captured on an accepted `start`
- `b`  in  WIDTH  subtrahend; captured on an accepted `start`
- `ready`  out  1  high in IDLE and DONE; `start` is accepted when this is high
- `busy`  out  1  high while in SHIFT
- `done`  out  1  one-cycle pulse; result valid
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH
- `borrow`  out  1  final borrow; 1 iff `a < b`, unsigned comparison
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_SIGNED_OVF_EN`

One clock; reset is asynchronous and active-low.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE or DONE, with `start` = 1:**
  - capture `a` and `b` into shift registers
  - clear the borrow register and the bit counter
  - clear `diff`
  - go to SHIFT
- **DONE, with `start` = 0:** go to IDLE. `diff`, `borrow` and `ovf` hold.
- **SHIFT, every cycle:**
  - `d = a0 ^ b0 ^ bin`
  - `bout = (~a0 & b0) | (~(a0 ^ b0) & bin)`
  - shift `d` into the MSB of `diff`; `diff` is a right shift register
  - shift the operand registers right by 1
  - `bin <= bout`
  - counter += 1
  - when the counter reaches WIDTH-1, the step is the last bit; go to DONE on that edge, with `borrow` = final `bout`.
- **`start` while in SHIFT:** ignored. There is no queueing and no error flag.
- **Operand stability:** `a` and `b` need to be stable only in the accept cycle.
- **Counter width:** `$clog2(WIDTH)` bits. The counter never wraps past WIDTH-1.
- **Outputs:** all registered. `ready` and `busy` decode the state. `done` = (state == DONE).
- **Reset:**
  - `rst_n` low at any time, including mid-SHIFT, forces IDLE immediately.
  - All registers clear: `diff` = 0, `borrow` = 0, `ovf` = 0, `done` = 0, `busy` = 0, `ready` = 1.
  - Any partial result is discarded.

## Timing
- An accepted `start` at edge k is followed by:
  - `busy` = 1 from k to k+WIDTH
  - DONE entered at edge k+WIDTH
  - `done` high for exactly one cycle, between edges k+WIDTH and k+WIDTH+1
- Latency is WIDTH+1 cycles from the `start` sample to the `done` cycle.
- **Back-to-back:** `start` asserted during the `done` cycle is accepted. The next result arrives WIDTH+1 cycles later, so sustained throughput is 1 operation per WIDTH+1 cycles.
- **Result visibility:** `diff` shows partial bits during SHIFT and is valid only when `done` = 1 or afterwards. It holds until the next accepted `start`, which clears it.
- **Reset release:** the first `start` may be sampled at the first rising edge after `rst_n` deasserts.

## Configuration
- Macro: `SERIAL_SUB_SIGNED_OVF_EN`.
- **Defined:**
  - Port `ovf` exists.
  - `ovf` is registered on the transition into DONE as `(a_msb != b_msb) && (d_msb != a_msb)`, using the captured operand MSBs and the final difference bit.
  - `ovf` holds with `diff`, and clears on an accepted `start` and on reset.
- **Undefined:**
  - The `ovf` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- **Basic subtract:** WIDTH=8, `a`=0x5A, `b`=0x3C, `start` for 1 cycle → `done` exactly 9 cycles later, `diff`=0x1E, `borrow`=0, `busy` high for 8 cycles.
- **Underflow:** `a`=0x00, `b`=0x01 → `diff`=0xFF, `borrow`=1. Then `a`=0xFF, `b`=0xFF → `diff`=0x00, `borrow`=0.
- **Ignored start:** `start` pulsed in SHIFT cycle 3 with different operands → first result unaffected, no extra `done`, FSM returns to IDLE.
- **Back-to-back:** `start` held high continuously with `a`=0x10, `b`=0x01, then `a`=0x03, `b`=0x05 → `done` pulses 9 cycles apart with `diff`=0x0F/`borrow`=0, then `diff`=0xFE/`borrow`=1.
- **Reset mid-operation:** `rst_n` pulled low in SHIFT cycle 4 → outputs immediately 0 and `ready`=1. A new `start` after release gives a correct result with no residual borrow.
- **Signed overflow:** with the macro defined, `a`=0x80, `b`=0x01 → `diff`=0x7F, `ovf`=1, `borrow`=0. Then `a`=0x7F, `b`=0xFF → `diff`=0x80, `ovf`=1, `borrow`=1. Then `a`=0x05, `b`=0x03 → `diff`=0x02, `ovf`=0, `borrow`=0.
